ram_responder: RTL and testbench
================================

// Module: ram_responder
// PURPOSE
//  Single-port word RAM model that answers the memory controller's RAM-side requests.
//  Receives ramREN/ramWEN/ramaddr/ramstore and returns ramstate/ramload with
//  programmable access latency.
//  Sits under the memory controller in the system top level; it is the responder end
//  of the ramstate handshake.
// PARAMETERS
//  DEPTH  1024  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH-4
//  LAT    2     BUSY cycles per access before ACCESS; legal range 1..15
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   synchronous, active-high reset
//  ramREN     in   1   read request, level held until ACCESS seen
//  ramWEN     in   1   write request, level held until ACCESS seen
//  ramaddr    in   32  byte address, word aligned
//  ramstore   in   32  write data
//  ramload    out  32  read data, valid only while ramstate==ACCESS on a read
//  ramstate   out  2   ramstate_t: FREE / BUSY / ACCESS / ERROR
//  rd_count   out  32  (RAM_STATS_EN only) completed reads
//  wr_count   out  32  (RAM_STATS_EN only) completed writes
// BEHAVIOUR
//  - Clock and reset are fixed: single clock CLK; RST is synchronous and active-high.
//  - Reset values:
//    - FSM = FREE, latency counter = 0, latched op/addr/data = 0.
//    - ramstate = FREE, ramload = 0, stats counters = 0.
//    - Array contents are NOT cleared.
//  - ramstate is decoded from registered FSM state only; it has no combinational path
//    from the request inputs.
//  - Definitions:
//    - req = ramREN ^ ramWEN.
//    - bad = ramREN & ramWEN, or (req & ramaddr[1:0] != 0), or (req & ramaddr >= 4*DEPTH).
//  - FREE:
//    - bad -> ERROR.
//    - req -> BUSY; latch op, addr and store; counter = LAT-1.
//  - BUSY:
//    - bad -> ERROR.
//    - !req -> FREE (abort, no side effect).
//    - op or addr differs from latch -> re-latch and restart counter at LAT-1.
//    - counter == 0 -> ACCESS.
//    - otherwise decrement the counter.
//    - Timing: request first seen at cycle 0 gives BUSY in cycles 1..LAT and ACCESS in
//      cycle LAT+1.
//  - ACCESS (exactly 1 cycle):
//    - Read: ramload = mem[addr>>2] of the latched addr.
//    - Write: mem[latched addr] <= latched store at the closing edge, provided the request
//      still matches the latch. If the request no longer matches, the write is dropped.
//    - Next state: bad -> ERROR; req -> BUSY with a fresh latch (a back-to-back request pays
//      the full LAT again, even at the same addr); else FREE.
//  - ERROR:
//    - Held while bad persists.
//    - !ramREN & !ramWEN -> FREE.
//    - A good req -> BUSY with a fresh latch.
//  - ramstore changing during BUSY does not restart the count; the value latched at
//    request entry is written.
//  - RST asserted in any state:
//    - FREE on the next edge.
//    - Any in-flight write is discarded.
//    - ramload = 0.
//  - ramload = 0 whenever the state is not ACCESS with a read op.
// CONFIGURATION
//  - RAM_STATS_EN defined:
//    - rd_count / wr_count ports exist.
//    - Each increments by 1 at the closing edge of a completed read / write ACCESS.
//    - Counters wrap at 2^32 and are cleared by RST.
//  - RAM_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - cpu_types_pkg holds ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3) and word_t.
//  - Local FSM enum, kept inside this module: R_FREE, R_BUSY, R_ACCESS, R_ERROR.
//  - Sub-module ram_array:
//    - DEPTH x 32 storage.
//    - Combinational read port; write port synchronous on we.
//    - Instantiated once; owns no control logic.
// TESTING
//  (LAT=2, DEPTH=1024)
//  1. RST high 2 cycles, then low, no requests -> ramstate FREE, ramload 0 indefinitely.
//  2. Write then read-back:
//     - WEN=1, addr 0x40, store 0xDEADBEEF held from cycle 0 -> BUSY cycles 1-2, ACCESS cycle 3.
//     - Drop WEN, then REN=1, addr 0x40 -> ACCESS with ramload 0xDEADBEEF.
//  3. Illegal requests:
//     - REN=WEN=1 -> ERROR the next cycle, held; both low -> FREE.
//     - addr 0x1002 (misaligned) -> ERROR.
//     - addr 0x1000 (out of range) -> ERROR.
//  4. Address change mid-access: REN addr 0x0; at cycle 2 switch to addr 0x8 -> BUSY restarts,
//     ACCESS at cycle 5 with mem[2].
//  5. Reset mid-write: WEN addr 0x10 store 0x12345678; RST at cycle 2 -> FREE; later read 0x10
//     returns the old value, not 0x12345678.
//  6. RAM_STATS_EN: 3 writes + 2 reads + 1 aborted read -> wr_count=3, rd_count=2.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: word and handshake-state types shared by the memory
// controller and the RAM responder.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if: RAM-side request/response bus between the memory
// controller (master) and the RAM responder (slave).
interface ram_responder_if;
   logic                      ramREN;
   logic                      ramWEN;
   cpu_types_pkg::word_t      ramaddr;
   cpu_types_pkg::word_t      ramstore;
   cpu_types_pkg::word_t      ramload;
   cpu_types_pkg::ramstate_t  ramstate;
   modport master(output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
   modport slave(input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/ram_responder_array.sv
// ram_array: DEPTH x 32 storage with a combinational read port and a
// synchronous write port; contents are never reset.
module ram_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];
   assign rdata = mem[addr];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
endmodule

// File: rtl/ram_responder.sv
// ram_responder: word RAM answering ramREN/ramWEN with LAT busy cycles per access.
// Define RAM_STATS_EN to add the rd_count / wr_count completion counters.
module ram_responder import cpu_types_pkg::*; #(
   parameter int DEPTH = 1024,
   parameter int LAT   = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
   ram_responder_if.slave         bus
`ifdef RAM_STATS_EN
   ,
   output logic [31:0]            rd_count,
   output logic [31:0]            wr_count
`endif
);
   localparam int         AW    = $clog2(DEPTH);
   localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;
   localparam logic [3:0] CNT0  = 4'(LAT - 1);
   localparam word_t      LIMIT = word_t'(4 * DEPTH);
   logic [1:0] st, st_n;
   logic [3:0] cnt, cnt_n;
   logic       op, lat_en, req, bad, same, we;
   word_t      a_l, d_l, rdata;
   assign req  = bus.ramREN ^ bus.ramWEN;
   assign bad  = (bus.ramREN & bus.ramWEN) |
                 (req & ((bus.ramaddr[1:0] != 2'b00) | (bus.ramaddr >= LIMIT)));
   assign same = req && (bus.ramWEN == op) && (bus.ramaddr == a_l);
   // A write lands only if the controller still holds the same request through ACCESS.
   assign we   = (st == R_ACCESS) && op && same && !RST;
   always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      lat_en = 1'b0;
      if (bad) st_n = R_ERROR;
      else if (st == R_BUSY) begin
         if (!req) st_n = R_FREE;
         else if (!same) begin
            lat_en = 1'b1;
            cnt_n  = CNT0;
         end
         else if (cnt == 4'd0) st_n = R_ACCESS;
         else cnt_n = cnt - 4'd1;
      end
      else if (req) begin
         st_n   = R_BUSY;
         lat_en = 1'b1;
         cnt_n  = CNT0;
      end
      else st_n = R_FREE;
   end
   always_ff @(posedge CLK)
      if (RST) begin
         st  <= R_FREE;
         cnt <= '0;
         op  <= 1'b0;
         a_l <= '0;
         d_l <= '0;
      end else begin
         st  <= st_n;
         cnt <= cnt_n;
         if (lat_en) begin
            op  <= bus.ramWEN;
            a_l <= bus.ramaddr;
            d_l <= bus.ramstore;
         end
      end
`ifdef RAM_STATS_EN
   always_ff @(posedge CLK)
      if (RST) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (st == R_ACCESS && !op) rd_count <= rd_count + 32'd1;
         if (we) wr_count <= wr_count + 32'd1;
      end
`endif
   assign bus.ramstate = ramstate_t'(st);
   assign bus.ramload  = (st == R_ACCESS && !op) ? rdata : '0;
   ram_array #(.DEPTH(DEPTH)) u_array (
      .clk   (CLK),
      .we    (we),
      .addr  (a_l[AW+1:2]),
      .wdata (d_l),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: randomized self-checking bench for ram_responder; the
// reference is a word array plus the LAT+1 access-latency rule.
module tb_ram_responder;
   import cpu_types_pkg::*;
   localparam int LAT   = 2;
   localparam int DEPTH = 1024;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   word_t mem_m [int];
   ram_responder_if bus();
`ifdef RAM_STATS_EN
   logic [31:0] rd_count, wr_count;
`endif
   ram_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .bus      (bus.slave)
`ifdef RAM_STATS_EN
      ,
      .rd_count (rd_count),
      .wr_count (wr_count)
`endif
   );
   always #5 CLK = ~CLK;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic idle();
      bus.ramREN = 1'b0;
      bus.ramWEN = 1'b0;
   endtask
   task automatic drive(input logic w, input word_t a, input word_t d);
      bus.ramREN   = !w;
      bus.ramWEN   = w;
      bus.ramaddr  = a;
      bus.ramstore = d;
   endtask
   // Holds a request until ACCESS, keeps it through the ACCESS closing edge, then releases.
   task automatic do_access(input logic w, input word_t a, input word_t d,
                            output int lat, output word_t ld);
      lat = -1;
      ld  = '0;
      drive(w, a, d);
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (bus.ramstate == ACCESS) begin
            lat = c;
            ld  = bus.ramload;
            break;
         end
      end
      tick();
      idle();
      tick();
      if (w && lat > 0) mem_m[int'(a >> 2)] = d;
   endtask
   task automatic test_reset();
      RST = 1'b1;
      idle();
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      tick();
      tick();
      RST = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++;
         if (bus.ramstate !== FREE || bus.ramload !== 32'h0) begin
            n_err++;
            $display("FAIL reset_idle: state=%0d load=%h want state=0 load=0", bus.ramstate, bus.ramload);
         end
      end
   endtask
   task automatic test_write_read();
      int lat;
      word_t ld;
      drive(1'b1, 32'h40, 32'hDEADBEEF);
      for (int c = 1; c <= LAT + 1; c++) begin
         tick();
         n_cmp++;
         if (bus.ramstate !== ((c <= LAT) ? BUSY : ACCESS)) begin
            n_err++;
            $display("FAIL write_timing c%0d: state=%0d want %0d", c, bus.ramstate, (c <= LAT) ? BUSY : ACCESS);
         end
      end
      n_cmp++;
      if (bus.ramload !== 32'h0) begin
         n_err++;
         $display("FAIL write_load_zero: load=%h want 0", bus.ramload);
      end
      tick();
      idle();
      tick();
      mem_m[16] = 32'hDEADBEEF;
      n_cmp++;
      if (bus.ramstate !== FREE) begin
         n_err++;
         $display("FAIL write_release: state=%0d want FREE", bus.ramstate);
      end
      do_access(1'b0, 32'h40, 32'h0, lat, ld);
      n_cmp++;
      if (lat !== LAT + 1 || ld !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL readback: lat=%0d load=%h want lat=%0d load=deadbeef", lat, ld, LAT + 1);
      end
   endtask
   task automatic test_illegal();
      int lat;
      word_t ld;
      bus.ramREN  = 1'b1;
      bus.ramWEN  = 1'b1;
      bus.ramaddr = 32'h40;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (bus.ramstate !== ERROR) begin
            n_err++;
            $display("FAIL both_req: state=%0d want ERROR", bus.ramstate);
         end
      end
      idle();
      tick();
      n_cmp++;
      if (bus.ramstate !== FREE) begin
         n_err++;
         $display("FAIL error_release: state=%0d want FREE", bus.ramstate);
      end
      drive(1'b0, 32'h1002, 32'h0);
      tick();
      n_cmp++;
      if (bus.ramstate !== ERROR) begin
         n_err++;
         $display("FAIL misaligned: state=%0d want ERROR", bus.ramstate);
      end
      drive(1'b0, 32'h1000, 32'h0);
      tick();
      n_cmp++;
      if (bus.ramstate !== ERROR) begin
         n_err++;
         $display("FAIL out_of_range: state=%0d want ERROR", bus.ramstate);
      end
      drive(1'b0, 32'h40, 32'h0);
      tick();
      n_cmp++;
      if (bus.ramstate !== BUSY) begin
         n_err++;
         $display("FAIL error_to_busy: state=%0d want BUSY", bus.ramstate);
      end
      idle();
      tick();
      do_access(1'b1, 32'hFFC, 32'hA5A5_0FFC, lat, ld);
      do_access(1'b0, 32'hFFC, 32'h0, lat, ld);
      n_cmp++;
      if (lat !== LAT + 1 || ld !== 32'hA5A5_0FFC) begin
         n_err++;
         $display("FAIL top_word: lat=%0d load=%h want lat=%0d load=a5a50ffc", lat, ld, LAT + 1);
      end
   endtask
   task automatic test_addr_change();
      int lat;
      word_t ld, b;
      b = $urandom;
      do_access(1'b1, 32'h0, ~b, lat, ld);
      do_access(1'b1, 32'h8, b, lat, ld);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      tick();
      bus.ramaddr = 32'h8;
      for (int c = 3; c <= 5; c++) begin
         tick();
         n_cmp++;
         if (bus.ramstate !== ((c < 5) ? BUSY : ACCESS)) begin
            n_err++;
            $display("FAIL addr_change c%0d: state=%0d want %0d", c, bus.ramstate, (c < 5) ? BUSY : ACCESS);
         end
      end
      n_cmp++;
      if (bus.ramload !== b) begin
         n_err++;
         $display("FAIL addr_change_load: load=%h want %h", bus.ramload, b);
      end
      tick();
      idle();
      tick();
   endtask
   task automatic test_reset_mid_write();
      int lat;
      word_t ld, old;
      old = $urandom;
      do_access(1'b1, 32'h10, old, lat, ld);
      drive(1'b1, 32'h10, 32'h12345678);
      for (int c = 1; c <= LAT + 1; c++) tick();
      n_cmp++;
      if (bus.ramstate !== ACCESS) begin
         n_err++;
         $display("FAIL rst_pre_access: state=%0d want ACCESS", bus.ramstate);
      end
      RST = 1'b1;
      tick();
      n_cmp++;
      if (bus.ramstate !== FREE || bus.ramload !== 32'h0) begin
         n_err++;
         $display("FAIL rst_mid_write: state=%0d load=%h want FREE/0", bus.ramstate, bus.ramload);
      end
      RST = 1'b0;
      idle();
      tick();
      do_access(1'b0, 32'h10, 32'h0, lat, ld);
      n_cmp++;
      if (ld !== old) begin
         n_err++;
         $display("FAIL rst_write_dropped: load=%h want %h", ld, old);
      end
   endtask
   task automatic test_back_to_back();
      int c1, c2;
      c1 = -1;
      c2 = -1;
      drive(1'b0, 32'h40, 32'h0);
      for (int c = 1; c <= 40 && c2 < 0; c++) begin
         tick();
         if (bus.ramstate == ACCESS) begin
            if (c1 < 0) c1 = c;
            else c2 = c - c1;
         end
      end
      n_cmp++;
      if (c1 !== LAT + 1 || c2 !== LAT + 1 || bus.ramload !== mem_m[16]) begin
         n_err++;
         $display("FAIL back_to_back: first=%0d second=%0d load=%h want %0d %0d %h",
                  c1, c2, bus.ramload, LAT + 1, LAT + 1, mem_m[16]);
      end
      tick();
      idle();
      tick();
   endtask
   task automatic test_random();
      int lat, k;
      word_t a, d, ld;
      for (int i = 0; i < 30; i++) begin
         k = $urandom_range(0, 3);
         a = word_t'($urandom_range(0, DEPTH - 1)) << 2;
         d = $urandom;
         if (k == 0 || !mem_m.exists(int'(a >> 2))) begin
            do_access(1'b1, a, d, lat, ld);
            n_cmp++;
            if (lat !== LAT + 1) begin
               n_err++;
               $display("FAIL rand_write %0d: lat=%0d want %0d", i, lat, LAT + 1);
            end
         end else if (k == 1) begin
            drive($urandom_range(0, 1) == 1, a | word_t'($urandom_range(1, 3)), d);
            tick();
            n_cmp++;
            if (bus.ramstate !== ERROR) begin
               n_err++;
               $display("FAIL rand_bad %0d: state=%0d want ERROR", i, bus.ramstate);
            end
            idle();
            tick();
         end else begin
            do_access(1'b0, a, 32'h0, lat, ld);
            n_cmp++;
            if (lat !== LAT + 1 || ld !== mem_m[int'(a >> 2)]) begin
               n_err++;
               $display("FAIL rand_read %0d: lat=%0d load=%h want %0d %h", i, lat, ld, LAT + 1, mem_m[int'(a >> 2)]);
            end
         end
      end
   endtask
`ifdef RAM_STATS_EN
   task automatic test_stats();
      int lat;
      word_t ld;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_cmp++;
      if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
         n_err++;
         $display("FAIL stats_reset: rd=%0d wr=%0d want 0 0", rd_count, wr_count);
      end
      for (int i = 0; i < 3; i++) do_access(1'b1, word_t'(32'h100 + 4 * i), $urandom, lat, ld);
      for (int i = 0; i < 2; i++) do_access(1'b0, word_t'(32'h100 + 4 * i), 32'h0, lat, ld);
      drive(1'b0, 32'h108, 32'h0);
      tick();
      idle();
      tick();
      n_cmp++;
      if (rd_count !== 32'd2 || wr_count !== 32'd3) begin
         n_err++;
         $display("FAIL stats_count: rd=%0d wr=%0d want 2 3", rd_count, wr_count);
      end
   endtask
`endif
   initial begin
      test_reset();
      test_write_read();
      test_illegal();
      test_addr_change();
      test_reset_mid_write();
      test_back_to_back();
      test_random();
`ifdef RAM_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
